iobuf_bank: RTL

IOBUF_BANK -- requirements
Module: iobuf_bank

---
 rtl/iobuf_pkg.sv | 13 +
 rtl/iobuf_turn_ctl.sv | 89 ++++++++
 rtl/iobuf_bank.sv | 73 +++++++
 3 files changed

// File: rtl/iobuf_pkg.sv
// Shared types and constants for the iobuf_bank tristate pad bank.
package iobuf_pkg;

  localparam int TURN_CNT_W = 4;

  typedef enum logic [1:0] {
    HIZ      = 2'd0,
    TURN_DRV = 2'd1,
    DRIVE    = 2'd2,
    TURN_HIZ = 2'd3
  } iobuf_state_e;

endpackage

// File: rtl/iobuf_turn_ctl.sv
// Direction FSM with bus-turnaround dead-cycle counter for iobuf_bank.
module iobuf_turn_ctl
  import iobuf_pkg::*;
#(
  parameter int TURN_CYCLES = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         t_i,
  output iobuf_state_e state_o,
  output logic         dir_o,
  output logic         busy_o
);

  localparam logic [TURN_CNT_W-1:0] CNT_ONE   = TURN_CNT_W'(1);
  localparam logic [TURN_CNT_W-1:0] TURN_LOAD =
    (TURN_CYCLES == 0) ? '0 : TURN_CNT_W'(TURN_CYCLES - 1);

  iobuf_state_e          state_q, state_d;
  logic [TURN_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HIZ;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HIZ: begin
        if (!t_i) begin
          if (TURN_CYCLES == 0) begin
            state_d = DRIVE;
          end else begin
            state_d = TURN_DRV;
            cnt_d   = TURN_LOAD;
          end
        end
      end
      TURN_DRV: begin
        // Pads are still released here, so backing out is always safe.
        if (t_i) begin
          state_d = HIZ;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = DRIVE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DRIVE: begin
        if (t_i) begin
          if (TURN_CYCLES == 0) begin
            state_d = HIZ;
          end else begin
            state_d = TURN_HIZ;
            cnt_d   = TURN_LOAD;
          end
        end
      end
      TURN_HIZ: begin
        // No abort: the far end must see the full dead time before anyone drives.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (t_i) begin
          state_d = HIZ;
        end else begin
          state_d = TURN_DRV;
          cnt_d   = TURN_LOAD;
        end
      end
      default: begin
        state_d = HIZ;
        cnt_d   = '0;
      end
    endcase
  end

  assign state_o = state_q;
  assign dir_o   = (state_q == DRIVE);
  assign busy_o  = (state_q == TURN_DRV) || (state_q == TURN_HIZ);

endmodule

// File: rtl/iobuf_bank.sv
// Bank of WIDTH bidirectional pads with registered drive/capture and turnaround FSM.
// Optional macro IOBUF_BANK_GTS_EN adds the global tristate override from glbl.GTS.
module iobuf_bank
  import iobuf_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               TURN_CYCLES = 1,
  parameter logic [WIDTH-1:0] INIT_OUT    = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] I,
  input  logic             T,
  inout  wire  [WIDTH-1:0] IO,
  output logic [WIDTH-1:0] O,
  output logic             O_VLD,
  output logic             DIR,
  output logic             BUSY
);

  iobuf_state_e     state;
  logic             dir;
  logic             gts;
  logic             drive_en;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             vld_q, vld_d;

  iobuf_turn_ctl #(
    .TURN_CYCLES(TURN_CYCLES)
  ) u_turn_ctl (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .t_i    (T),
    .state_o(state),
    .dir_o  (dir),
    .busy_o (BUSY)
  );

`ifdef IOBUF_BANK_GTS_EN
  assign gts = glbl.GTS;
`else
  assign gts = 1'b0;
`endif

  assign out_d = I;
  assign o_d   = IO;
  assign vld_d = (state == HIZ);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q <= INIT_OUT;
      o_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      o_q   <= o_d;
      vld_q <= vld_d;
    end
  end

  // RST_N in the enable releases the pads combinationally, not at the next edge.
  assign drive_en = dir & RST_N & ~gts;

  for (genvar b = 0; b < WIDTH; b++) begin : g_pad
    assign IO[b] = drive_en ? out_q[b] : 1'bz;
  end

  assign O     = o_q;
  assign O_VLD = vld_q & ~gts;
  assign DIR   = dir;

endmodule
